// File: rtl/prime_collector.sv
// prime_collector
//   Consumer of the prime-search stage. Captures every newly reported prime
//   into a FIFO that is drained with a valid/ready handshake. Also tracks
//   twin-prime count and largest gap, and raises done once the search has
//   passed numMax and the FIFO has drained.
//
// Optional feature macro: PRIME_COLLECTOR_STATS_EN
//   defined   : twinCount / maxGap statistics are implemented
//   undefined : statistics logic omitted, twinCount and maxGap read 0
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   numMax         search limit (same value the search stage uses)
//   prime          most recent prime from upstream
//   numberChecked  candidate currently tested upstream
//   numberOfPrimes running prime count upstream (a change marks a new prime)
//   out_ready      consumer accepts head entry
//   out_valid      FIFO non-empty
//   out_prime      FIFO head entry
//   fifo_count     current occupancy (0..DEPTH)
//   full           fifo_count == DEPTH
//   overflow       sticky, a prime was dropped because the FIFO was full
//   twinCount      number of consecutive prime pairs with gap 2 (saturating)
//   maxGap         largest gap between consecutive captured primes
//   done           search complete and FIFO empty (registered)
//
// States
//   IDLE | waiting for a non-zero numMax
//   RUN  | search in progress, count changes are captured
//   DONE | numberChecked reached numMax, held until reset
module prime_collector #(
  parameter int WIDTH  = 11,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  numMax,
  input  logic [WIDTH-1:0]  prime,
  input  logic [WIDTH-1:0]  numberChecked,
  input  logic [WIDTH-1:0]  numberOfPrimes,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_prime,
  output logic [ADDR_W:0]   fifo_count,
  output logic              full,
  output logic              overflow,
  output logic [WIDTH-1:0]  twinCount,
  output logic [WIDTH-1:0]  maxGap,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  prev_count_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q;
  logic              done_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic prime_evt, push, pop;

  assign out_valid  = (count_q != '0);
  assign full       = (count_q == CNT_FULL);
  assign out_prime  = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign done       = done_q;

  assign prime_evt = (state_q == RUN) && (numberOfPrimes != prev_count_q);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = prime_evt && (!full || pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (numMax != '0) state_d = RUN;
      RUN:     if (numberChecked >= numMax) state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      prev_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      prev_count_q <= numberOfPrimes;
      count_q      <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= prime;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (prime_evt && full && !pop) overflow_q <= 1'b1;
      done_q <= ((state_q == DONE) || (numMax == '0)) && (count_q == '0);
    end
  end

`ifdef PRIME_COLLECTOR_STATS_EN
  localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] W_TWO = WIDTH'(2);

  logic [WIDTH-1:0] last_prime_q, twin_q, max_gap_q, gap;
  logic             have_last_q;

  assign gap = prime - last_prime_q;

  // Statistics follow every event, including primes the FIFO had to drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_prime_q <= '0;
      have_last_q  <= 1'b0;
      twin_q       <= '0;
      max_gap_q    <= '0;
    end else if (prime_evt) begin
      last_prime_q <= prime;
      have_last_q  <= 1'b1;
      if (have_last_q) begin
        if ((gap == W_TWO) && (twin_q != '1)) twin_q <= twin_q + W_ONE;
        if (gap > max_gap_q) max_gap_q <= gap;
      end
    end
  end

  assign twinCount = twin_q;
  assign maxGap    = max_gap_q;
`else
  assign twinCount = '0;
  assign maxGap    = '0;
`endif

endmodule

// File: tb/tb_prime_collector.sv
module tb_prime_collector;

  localparam int W = 11;
  localparam int D = 16;
  localparam int A = 4;
`ifdef PRIME_COLLECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] numMax = '0;
  logic [W-1:0] prime = '0;
  logic [W-1:0] numberChecked = '0;
  logic [W-1:0] numberOfPrimes = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_prime;
  logic [A:0]   fifo_count;
  logic         full;
  logic         overflow;
  logic [W-1:0] twinCount;
  logic [W-1:0] maxGap;
  logic         done;

  int total = 0;
  int bad   = 0;

  prime_collector #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
    .clk(clk), .rst(rst), .numMax(numMax), .prime(prime),
    .numberChecked(numberChecked), .numberOfPrimes(numberOfPrimes),
    .out_ready(out_ready), .out_valid(out_valid), .out_prime(out_prime),
    .fifo_count(fifo_count), .full(full), .overflow(overflow),
    .twinCount(twinCount), .maxGap(maxGap), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: act=%0d req=%0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Scoreboard/reference: expected FIFO contents and FSM phase, advanced at
  // each negedge using the inputs the DUT will sample on the next posedge.
  int sb_q[$];
  int m_state = 0;
  int m_prev  = 0;

  always @(negedge clk) begin : monitor
    bit pop, ev;
    int exp_v;
    if (!rst) begin
      m_state = 0;
      m_prev  = 0;
      sb_q.delete();
    end else begin
      chk("valid", out_valid, (sb_q.size() != 0) ? 1 : 0);
      chk("count", fifo_count, sb_q.size());
      pop = (sb_q.size() != 0) && out_ready;
      ev  = (m_state == 1) && (int'(numberOfPrimes) != m_prev);
      if (pop) begin
        exp_v = sb_q.pop_front();
        chk("pop_data", out_prime, exp_v);
      end
      if (ev && sb_q.size() < D) sb_q.push_back(int'(prime));
      m_prev = int'(numberOfPrimes);
      if (m_state == 0 && numMax != 0) m_state = 1;
      else if (m_state == 1 && numberChecked >= numMax) m_state = 2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int nm);
    rst = 1'b0;
    numMax = W'(nm);
    numberChecked = '0;
    numberOfPrimes = '0;
    prime = '0;
    tick();
    tick();
  endtask

  task automatic step(input int n);
    numberChecked = W'(n);
    if (is_prime(n)) begin
      prime = W'(n);
      numberOfPrimes = numberOfPrimes + 1'b1;
    end
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_prime"}, out_prime, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_twin"}, twinCount, 0);
    chk({tag, "_mgap"}, maxGap, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 40 && out_valid; k++) tick();
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_done", done, 1);
    chk("sb_left", sb_q.size(), 0);
  endtask

  typedef struct {
    int num_max;
    bit ready;
    int cnt;
    bit full;
    bit ovf;
    int twin;
    int mgap;
    bit done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{20, 1'b1, 0,  1'b0, 1'b0, 4, 4, 1'b1};
    vecs[1] = '{10, 1'b1, 0,  1'b0, 1'b0, 2, 2, 1'b1};
    vecs[2] = '{20, 1'b0, 8,  1'b0, 1'b0, 4, 4, 1'b0};
    vecs[3] = '{70, 1'b0, 16, 1'b1, 1'b1, 7, 6, 1'b0};
    vecs[4] = '{0,  1'b1, 0,  1'b0, 1'b0, 0, 0, 1'b1};
    vecs[5] = '{2,  1'b1, 0,  1'b0, 1'b0, 0, 0, 1'b1};

    for (int i = 0; i < 6; i++) begin
      int lim;
      out_ready = vecs[i].ready;
      do_reset(vecs[i].num_max);
      chk_zero("rst");
      rst = 1'b1;
      tick();
      chk("done_rel", done, (vecs[i].num_max == 0) ? 1 : 0);
      lim = (vecs[i].num_max == 0) ? 7 : vecs[i].num_max;
      for (int n = 2; n <= lim; n++) step(n);
      repeat (3) tick();
      chk("v_count", fifo_count, vecs[i].cnt);
      chk("v_full", full, vecs[i].full);
      chk("v_ovf", overflow, vecs[i].ovf);
      chk("v_twin", twinCount, STATS ? vecs[i].twin : 0);
      chk("v_mgap", maxGap, STATS ? vecs[i].mgap : 0);
      chk("v_done", done, vecs[i].done);
      drain();
    end

    // Full FIFO with a pop in the same cycle the next prime arrives.
    out_ready = 1'b0;
    do_reset(70);
    rst = 1'b1;
    tick();
    for (int n = 2; n <= 58; n++) step(n);
    chk("pp_full_before", full, 1);
    chk("pp_count_before", fifo_count, 16);
    out_ready = 1'b1;
    step(59);
    chk("pp_count_after", fifo_count, 16);
    chk("pp_ovf", overflow, 0);
    for (int n = 60; n <= 70; n++) step(n);
    drain();
    chk("pp_ovf_end", overflow, 0);

    // Reset in the middle of a run, then restart with a smaller limit.
    out_ready = 1'b0;
    do_reset(20);
    rst = 1'b1;
    tick();
    for (int n = 2; n <= 11; n++) step(n);
    chk("mid_count", fifo_count, 5);
    rst = 1'b0;
    numberChecked = '0;
    numberOfPrimes = '0;
    prime = '0;
    tick();
    chk_zero("mid_rst");
    numMax = W'(10);
    rst = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int n = 2; n <= 10; n++) step(n);
    repeat (3) tick();
    chk("mid_twin", twinCount, STATS ? 2 : 0);
    chk("mid_mgap", maxGap, STATS ? 2 : 0);
    chk("mid_done", done, 1);
    chk("mid_sb_left", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prime_collector.md
Name: prime_collector

Overview:
- Downstream consumer of the prime-search stage. That stage emits the `prime`, `numberChecked` and `numberOfPrimes` buses.
- Detects each newly found prime and buffers it in a FIFO drained by a valid/ready handshake.
- Tracks gap statistics: twin-prime count and largest gap.
- Flags completion once the search has passed `numMax` and the FIFO has drained.

Parameters:
- WIDTH, 11, width of the prime, count and limit buses.
- DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- numMax  input  WIDTH  search limit, same value driven to the prime-search stage.
- prime  input  WIDTH  most recent prime from the upstream stage.
- numberChecked  input  WIDTH  candidate currently being tested upstream.
- numberOfPrimes  input  WIDTH  running prime count upstream.
- out_ready  input  1  consumer accepts the head entry.
- out_valid  output  1  FIFO non-empty.
- out_prime  output  WIDTH  FIFO head entry.
- fifo_count  output  ADDR_W+1  current occupancy.
- full  output  1  fifo_count == DEPTH.
- overflow  output  1  sticky; a prime was dropped.
- twinCount  output  WIDTH  number of consecutive primes with gap 2.
- maxGap  output  WIDTH  largest gap between consecutive captured primes.
- done  output  1  search complete and FIFO empty.

Behaviour:
- **Reset:** rst==0 at a clk edge resets everything.
  - Outputs: out_valid=0, out_prime=0, fifo_count=0, full=0, overflow=0, twinCount=0, maxGap=0, done=0.
  - Internal: prev_count=0, last_prime=0, have_last=0, pointers=0, state=IDLE.
  - Reset mid-operation discards all FIFO contents and statistics.
- **States:**
  - IDLE -> RUN on the first active cycle with numMax != 0. numMax==0 stays in IDLE, with done=1 and the FIFO empty.
  - RUN -> DONE when numberChecked >= numMax.
  - DONE holds until reset.
- **Prime event:** event = (state==RUN) && (numberOfPrimes != prev_count).
  - prev_count <= numberOfPrimes every active cycle, in all states.
  - A count change in the same cycle as the RUN->DONE transition is still captured.
- **Push:** on an event, prime is written at wr_ptr at that edge.
  - out_valid and out_prime reflect it from the next cycle: one-cycle latency.
- **Pop:** occurs when out_valid && out_ready; rd_ptr advances.
  - out_prime is the combinational read of mem[rd_ptr].
- **Full:** event && full && !pop -> prime dropped, overflow<=1 (sticky until reset).
  - Statistics still update for the dropped prime.
- **Full with simultaneous pop:** push and pop both accepted; fifo_count unchanged.
- **Empty:** no pop is possible. An event while empty sets fifo_count to 1.
- **Pointers:** ADDR_W bits, wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- **Gap:** gap = prime - last_prime, WIDTH-bit unsigned.
  - Computed only when have_last=1.
  - On an event: last_prime<=prime, have_last<=1.
  - gap==2 -> twinCount+1, saturating at all-ones.
  - gap>maxGap -> maxGap<=gap.
- **done:** (state==DONE || numMax==0) && fifo_count==0; registered.

Optional Feature:
- PRIME_COLLECTOR_STATS_EN
  - Defined: twinCount, maxGap, last_prime and have_last are implemented as described.
  - Undefined: that logic is omitted and twinCount, maxGap read constant 0. FIFO, overflow and done are unchanged.

Test Plan:
- **Full run:** numMax=20, DEPTH=16, out_ready=1, upstream model emits 2,3,5,7,11,13,17,19 -> popped stream 2,3,5,7,11,13,17,19; twinCount=4; maxGap=4; overflow=0; done=1 after drain.
- **Overflow:** DEPTH=4, out_ready=0, numMax=20 -> fifo_count=4, full=1, overflow=1.
  - Then out_ready=1 -> pops 2,3,5,7, then out_valid=0.
- **Full with simultaneous push/pop:** DEPTH=4 full with 2,3,5,7, out_ready=1 in the cycle the prime 11 arrives -> 2 popped, 11 accepted, fifo_count stays 4, overflow=0.
- **Reset mid-operation:** assert rst=0 for one edge after 5 captured -> all outputs 0.
  - Restart numMax=10 -> stream 2,3,5,7; twinCount=2; maxGap=2.
- **Zero limit:** numMax=0 -> state stays IDLE, no captures, done=1 one cycle after reset release.
- **Macro undefined:** numMax=20 -> stream identical to the full-run case, twinCount=0, maxGap=0.
